// File: rtl/msp430_reset_sequencer_pkg.sv
// msp430_rst_pkg: shared FSM state type and reset-cause bit indices for the reset sequencer
package msp430_rst_pkg;
  typedef enum logic [1:0] {ST_POR, ST_IO, ST_PUC, ST_RUN} rst_state_t;
  localparam int RST_CAUSE_POR = 0;
  localparam int RST_CAUSE_WDT = 1;
  localparam int RST_CAUSE_DBG = 2;
endpackage

// File: rtl/msp430_reset_sequencer_if.sv
// msp430_reset_sequencer_if: warm-reset requests in; por/gts/puc domain resets, done flag and sticky cause out
interface msp430_reset_sequencer_if;
  logic       wdt_rst_i;
  logic       dbg_rst_i;
  logic       por_o;
  logic       gts_o;
  logic       puc_rst_o;
  logic       rst_done_o;
  logic [2:0] rst_cause_o;
  modport slave (input wdt_rst_i, dbg_rst_i, output por_o, gts_o, puc_rst_o, rst_done_o, rst_cause_o);
  modport master (output wdt_rst_i, dbg_rst_i, input por_o, gts_o, puc_rst_o, rst_done_o, rst_cause_o);
endinterface

// File: rtl/msp430_reset_sequencer_sync.sv
// msp430_sync_cell: 2-flop synchronizer (clk, async active-low rst_n clears to 0, d_i in, q_o out)
module msp430_sync_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/msp430_reset_sequencer.sv
// msp430_reset_sequencer: counted POR->IO->PUC->RUN release (mclk, reset_n, gsr_i, rst_if) with warm PUC and cause capture
module msp430_reset_sequencer
  import msp430_rst_pkg::*;
#(
  parameter int POR_CYCLES = 16,
  parameter int TOC_CYCLES = 4,
  parameter int PUC_CYCLES = 8,
  parameter int CNT_W      = 8
) (
  input  logic                      mclk,
  input  logic                      reset_n,
  input  logic                      gsr_i,
  msp430_reset_sequencer_if.slave   rst_if
);
  if (POR_CYCLES < 1 || TOC_CYCLES < 1 || PUC_CYCLES < 1) begin : g_bad_min
    $error("msp430_reset_sequencer: *_CYCLES must be >= 1");
  end
  if (POR_CYCLES > 2**CNT_W || TOC_CYCLES > 2**CNT_W || PUC_CYCLES > 2**CNT_W) begin : g_bad_w
    $error("msp430_reset_sequencer: *_CYCLES exceeds 2^CNT_W");
  end
  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOC_LAST = CNT_W'(TOC_CYCLES - 1);
  localparam logic [CNT_W-1:0] PUC_LAST = CNT_W'(PUC_CYCLES - 1);
  localparam logic [2:0]       CAUSE_POR = 3'(1 << RST_CAUSE_POR);
  logic rel_s, gsr_s;
  msp430_sync_cell u_rel (.clk(mclk), .rst_n(reset_n), .d_i(1'b1), .q_o(rel_s));
  msp430_sync_cell u_gsr (.clk(mclk), .rst_n(reset_n), .d_i(gsr_i), .q_o(gsr_s));
  rst_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             por_q, por_d, gts_q, gts_d, puc_q, puc_d, done_q, done_d;
  logic [2:0]       cause_q, cause_d;
  always_ff @(posedge mclk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_POR;
      cnt_q   <= '0;
      por_q   <= 1'b1;
      gts_q   <= 1'b1;
      puc_q   <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      por_q   <= por_d;
      gts_q   <= gts_d;
      puc_q   <= puc_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    por_d   = por_q;
    gts_d   = gts_q;
    puc_d   = puc_q;
    done_d  = done_q;
    cause_d = cause_q;
    if (gsr_s) begin
      state_d = ST_POR;
      cnt_d   = '0;
      por_d   = 1'b1;
      gts_d   = 1'b1;
      puc_d   = 1'b1;
      done_d  = 1'b0;
      cause_d = CAUSE_POR;
    end else if (rel_s) begin
      case (state_q)
        ST_POR: begin
          cnt_d = (cnt_q == POR_LAST) ? '0 : cnt_q + CNT_W'(1);
          if (cnt_q == POR_LAST) begin
            state_d = ST_IO;
            por_d   = 1'b0;
          end
        end
        ST_IO: begin
          cnt_d = (cnt_q == TOC_LAST) ? '0 : cnt_q + CNT_W'(1);
          if (cnt_q == TOC_LAST) begin
            state_d = ST_PUC;
            gts_d   = 1'b0;
          end
        end
        ST_PUC: begin
          cnt_d = (cnt_q == PUC_LAST) ? '0 : cnt_q + CNT_W'(1);
          if (cnt_q == PUC_LAST) begin
            state_d = ST_RUN;
            puc_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          if (rst_if.wdt_rst_i || rst_if.dbg_rst_i) begin
            state_d                = ST_PUC;
            cnt_d                  = '0;
            puc_d                  = 1'b1;
            done_d                 = 1'b0;
            cause_d                = '0;
            cause_d[RST_CAUSE_WDT] = rst_if.wdt_rst_i;
            cause_d[RST_CAUSE_DBG] = rst_if.dbg_rst_i;
          end
        end
      endcase
    end
  end
  assign rst_if.por_o       = por_q;
  assign rst_if.gts_o       = gts_q;
  assign rst_if.puc_rst_o   = puc_q;
  assign rst_if.rst_done_o  = done_q;
  assign rst_if.rst_cause_o = cause_q;
endmodule

// File: tb/tb_msp430_reset_sequencer.sv
// tb_msp430_reset_sequencer: directed checks of cold start, warm resets, gsr and async reset, plus a 1/1/1 instance
module tb_msp430_reset_sequencer;
  logic mclk = 1'b0;
  logic reset_n, gsr_i;
  int checks = 0;
  int errors = 0;
  always #5 mclk = ~mclk;
  msp430_reset_sequencer_if u_if ();
  msp430_reset_sequencer_if u_if2 ();
  msp430_reset_sequencer u_dut (.mclk(mclk), .reset_n(reset_n), .gsr_i(gsr_i), .rst_if(u_if));
  msp430_reset_sequencer #(.POR_CYCLES(1), .TOC_CYCLES(1), .PUC_CYCLES(1)) u_dut2 (
    .mclk(mclk), .reset_n(reset_n), .gsr_i(gsr_i), .rst_if(u_if2));
  task automatic edges(input int n);
    repeat (n) @(posedge mclk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic por, gts, puc, done, input logic [2:0] cause);
    chk({tag, ".por"}, 3'(u_if.por_o), 3'(por));
    chk({tag, ".gts"}, 3'(u_if.gts_o), 3'(gts));
    chk({tag, ".puc"}, 3'(u_if.puc_rst_o), 3'(puc));
    chk({tag, ".done"}, 3'(u_if.rst_done_o), 3'(done));
    chk({tag, ".cause"}, u_if.rst_cause_o, cause);
  endtask
  initial begin
    reset_n = 1'b0;
    gsr_i = 1'b0;
    u_if.wdt_rst_i = 1'b0;
    u_if.dbg_rst_i = 1'b0;
    u_if2.wdt_rst_i = 1'b0;
    u_if2.dbg_rst_i = 1'b0;
    edges(3);
    chk_all("reset", 1, 1, 1, 0, 3'b001);
    @(negedge mclk) reset_n = 1'b1;
    edges(19);
    chk_all("io_e18", 0, 1, 1, 0, 3'b001);
    #1 reset_n = 1'b0;
    #1;
    chk_all("async_rst", 1, 1, 1, 0, 3'b001);
    @(negedge mclk) reset_n = 1'b1;
    edges(2);
    chk("p1_e1.por", 3'(u_if2.por_o), 3'd1);
    edges(1);
    chk("p1_e2.por", 3'(u_if2.por_o), 3'd0);
    chk("p1_e2.gts", 3'(u_if2.gts_o), 3'd1);
    edges(1);
    chk("p1_e3.gts", 3'(u_if2.gts_o), 3'd0);
    chk("p1_e3.puc", 3'(u_if2.puc_rst_o), 3'd1);
    edges(1);
    chk("p1_e4.puc", 3'(u_if2.puc_rst_o), 3'd0);
    chk("p1_e4.done", 3'(u_if2.rst_done_o), 3'd1);
    edges(12);
    chk_all("cold_e16", 1, 1, 1, 0, 3'b001);
    edges(1);
    chk_all("cold_e17", 0, 1, 1, 0, 3'b001);
    edges(3);
    chk_all("cold_e20", 0, 1, 1, 0, 3'b001);
    edges(1);
    chk_all("cold_e21", 0, 0, 1, 0, 3'b001);
    edges(7);
    chk_all("cold_e28", 0, 0, 1, 0, 3'b001);
    edges(1);
    chk_all("cold_e29", 0, 0, 0, 1, 3'b001);
    edges(2);
    u_if.wdt_rst_i = 1'b1;
    edges(1);
    u_if.wdt_rst_i = 1'b0;
    chk_all("wdt_w", 0, 0, 1, 0, 3'b010);
    edges(7);
    chk_all("wdt_w7", 0, 0, 1, 0, 3'b010);
    edges(1);
    chk_all("wdt_w8", 0, 0, 0, 1, 3'b010);
    edges(2);
    u_if.wdt_rst_i = 1'b1;
    u_if.dbg_rst_i = 1'b1;
    edges(1);
    u_if.wdt_rst_i = 1'b0;
    u_if.dbg_rst_i = 1'b0;
    chk_all("both_w", 0, 0, 1, 0, 3'b110);
    edges(3);
    u_if.wdt_rst_i = 1'b1;
    edges(1);
    u_if.wdt_rst_i = 1'b0;
    chk_all("ign_w4", 0, 0, 1, 0, 3'b110);
    edges(3);
    chk_all("both_w7", 0, 0, 1, 0, 3'b110);
    edges(1);
    chk_all("both_w8", 0, 0, 0, 1, 3'b110);
    edges(2);
    gsr_i = 1'b1;
    edges(2);
    chk_all("gsr_g1", 0, 0, 0, 1, 3'b110);
    edges(1);
    chk_all("gsr_g2", 1, 1, 1, 0, 3'b001);
    edges(2);
    gsr_i = 1'b0;
    edges(17);
    chk_all("gsr_h16", 1, 1, 1, 0, 3'b001);
    edges(1);
    chk_all("gsr_h17", 0, 1, 1, 0, 3'b001);
    edges(4);
    chk_all("gsr_h21", 0, 0, 1, 0, 3'b001);
    edges(7);
    chk_all("gsr_h28", 0, 0, 1, 0, 3'b001);
    edges(1);
    chk_all("gsr_h29", 0, 0, 0, 1, 3'b001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
